// File: rtl/rsa_stream_ctrl.sv
// Byte-stream front end for Rsa256Core: assembles n, d and ciphertext from an
// 8-bit input stream, starts the core, and serialises the result back out.
module rsa_stream_ctrl #(
    parameter int unsigned WORD_BYTES = 32,
    parameter int unsigned OUT_BYTES  = 31
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [7:0]                i_rx_data,
    input  logic                      i_rx_valid,
    output logic                      o_rx_ready,
    output logic [7:0]                o_tx_data,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready,
    input  logic                      i_key_reload,
    output logic                      o_core_start,
    output logic [WORD_BYTES*8-1:0]   o_core_n,
    output logic [WORD_BYTES*8-1:0]   o_core_d,
    output logic [WORD_BYTES*8-1:0]   o_core_a,
    input  logic [WORD_BYTES*8-1:0]   i_core_a_pow_d,
    input  logic                      i_core_finished
);

    localparam int unsigned OP_W  = WORD_BYTES * 8;
    localparam int unsigned RES_W = OUT_BYTES * 8;
    localparam int unsigned CNT_W = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        GET_N,
        GET_D,
        GET_A,
        START,
        WAIT,
        SEND
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [OP_W-1:0]    n_q, d_q, a_q;
    logic [RES_W-1:0]   res_q;

    logic rx_ready, tx_valid, core_start;
    logic rx_fire, tx_fire, last_in, last_out;

    assign last_in  = (cnt_q == CNT_W'(WORD_BYTES - 1));
    assign last_out = (cnt_q == CNT_W'(OUT_BYTES - 1));
    assign rx_fire  = rx_ready & i_rx_valid;
    assign tx_fire  = tx_valid & i_tx_ready;

    always_comb begin
        state_d    = state_q;
        rx_ready   = 1'b0;
        tx_valid   = 1'b0;
        core_start = 1'b0;
        case (state_q)
            GET_N: begin
                rx_ready = 1'b1;
                if (i_rx_valid && last_in) state_d = GET_D;
            end
            GET_D: begin
                rx_ready = 1'b1;
                if (i_rx_valid && last_in) state_d = GET_A;
            end
            GET_A: begin
                // A reload request at a word boundary takes priority over any byte offered.
                if (i_key_reload && cnt_q == '0) begin
                    state_d = GET_N;
                end else begin
                    rx_ready = 1'b1;
                    if (i_rx_valid && last_in) state_d = START;
                end
            end
            START: begin
                core_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (i_core_finished) state_d = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                if (i_tx_ready && last_out) state_d = GET_A;
            end
            default: state_d = GET_N;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= GET_N;
            cnt_q   <= '0;
            n_q     <= '0;
            d_q     <= '0;
            a_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                GET_N: if (rx_fire) begin
                    n_q   <= {n_q[OP_W-9:0], i_rx_data};
                    cnt_q <= last_in ? '0 : cnt_q + 1'b1;
                end
                GET_D: if (rx_fire) begin
                    d_q   <= {d_q[OP_W-9:0], i_rx_data};
                    cnt_q <= last_in ? '0 : cnt_q + 1'b1;
                end
                GET_A: if (rx_fire) begin
                    a_q   <= {a_q[OP_W-9:0], i_rx_data};
                    cnt_q <= last_in ? '0 : cnt_q + 1'b1;
                end
                WAIT: if (i_core_finished) begin
                    res_q <= i_core_a_pow_d[RES_W-1:0];
                    cnt_q <= '0;
                end
                // Result is shifted out MSB first, so the head byte is always the current one.
                SEND: if (tx_fire) begin
                    res_q <= res_q << 8;
                    cnt_q <= last_out ? '0 : cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_rx_ready   = rx_ready & ~i_rst;
    assign o_tx_valid   = tx_valid;
    assign o_tx_data    = tx_valid ? res_q[RES_W-1 -: 8] : 8'h00;
    assign o_core_start = core_start;
    assign o_core_n     = n_q;
    assign o_core_d     = d_q;
    assign o_core_a     = a_q;

endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// Directed bench for rsa_stream_ctrl with a mock core that raises finished
// 20 cycles after each start pulse and returns a preset result.
module tb_rsa_stream_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic         key_reload = 1'b0;
  logic         core_start;
  logic [255:0] core_n, core_d, core_a;
  logic [255:0] core_a_pow_d = '0;
  logic         core_finished = 1'b0;

  int tests = 0;
  int fails = 0;
  int mock_cnt = 0;
  int start_count = 0;

  localparam logic [255:0] N_VAL = 256'hCA3586E7_EA485F3B_0A222A4C_79F7DD12_E85388EC_CDEE4035_940D774C_029CF831;
  localparam logic [255:0] D_VAL = 256'hB6ACE0B1_4720169C_CE5A33E1_9B7D1B34_A3B8A5CC_14E23D0D_55C32A0E_1C5A6BD9;
  localparam logic [255:0] A1    = 256'h1;
  localparam logic [255:0] A2    = 256'h5A5A0000_11112222_33334444_55556666_77778888_9999AAAA_BBBBCCCC_DDDDEEEE;
  localparam logic [255:0] N2    = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;

  rsa_stream_ctrl #(.WORD_BYTES(32), .OUT_BYTES(31)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .o_rx_ready(rx_ready),
    .o_tx_data(tx_data),
    .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready),
    .i_key_reload(key_reload),
    .o_core_start(core_start),
    .o_core_n(core_n),
    .o_core_d(core_d),
    .o_core_a(core_a),
    .i_core_a_pow_d(core_a_pow_d),
    .i_core_finished(core_finished)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    core_finished <= 1'b0;
    if (core_start) start_count <= start_count + 1;
    if (rst) mock_cnt <= 0;
    else if (core_start) mock_cnt <= 20;
    else if (mock_cnt > 0) begin
      mock_cnt <= mock_cnt - 1;
      if (mock_cnt == 1) core_finished <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    tests++;
    if (obs !== expv) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Offers one byte and returns #1 after the edge on which it was accepted.
  task automatic put_byte(input logic [7:0] b);
    int t;
    logic acc;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      acc = rx_ready;
      @(posedge clk); #1;
      if (acc) break;
      t++;
      if (t >= 50) begin
        chk("rx_timeout", acc, 1'b1);
        break;
      end
    end
  endtask

  task automatic put_word(input logic [255:0] w);
    for (int i = 0; i < 32; i++) put_byte(w[255 - 8*i -: 8]);
  endtask

  task automatic recv(input logic toggle, input logic [255:0] res,
                      input logic [255:0] exp_a, input int nbytes, output int got);
    int cyc;
    logic [7:0] held;
    logic stalled, prev_fin, first;
    got = 0; cyc = 0; stalled = 1'b0; prev_fin = 1'b0; first = 1'b1; held = 8'h00;
    while (got < nbytes && cyc < 400) begin
      tx_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (tx_valid) begin
        if (first) begin
          chk("tx_latency", prev_fin, 1'b1);
          chk("core_a_hold", core_a, exp_a);
          first = 1'b0;
        end
        if (stalled) chk("tx_stable", tx_data, held);
        if (tx_ready) begin
          chk($sformatf("tx_byte%0d", got), tx_data, res[247 - 8*got -: 8]);
          got++;
          stalled = 1'b0;
        end else begin
          held    = tx_data;
          stalled = 1'b1;
        end
      end
      prev_fin = core_finished;
      @(posedge clk); #1;
      cyc++;
    end
    tx_ready = 1'b0;
  endtask

  logic [255:0] res1, res2;
  int got;

  initial begin
    res1 = '0;
    res2 = '0;
    res1[255:248] = 8'hFF;
    res2[255:248] = 8'hEE;
    for (int i = 0; i < 31; i++) begin
      res1[247 - 8*i -: 8] = 8'(i + 1);
      res2[247 - 8*i -: 8] = 8'(i + 128);
    end

    @(posedge clk); @(posedge clk); #1;
    chk("rst_rx_ready", rx_ready, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_core_n", core_n, 256'h0);
    rst = 1'b0;
    #1;
    chk("idle_rx_ready", rx_ready, 1'b1);

    core_a_pow_d = res1;
    put_word(N_VAL);
    put_word(D_VAL);
    put_word(A1);
    rx_valid = 1'b0;
    chk("start_pulse", core_start, 1'b1);
    chk("core_n", core_n, N_VAL);
    chk("core_d", core_d, D_VAL);
    chk("core_a", core_a, A1);
    chk("busy_rx_ready", rx_ready, 1'b0);
    @(posedge clk); #1;
    chk("start_once", core_start, 1'b0);
    chk("start_count1", start_count, 1);

    recv(1'b0, res1, A1, 31, got);
    chk("tx_count1", got, 31);
    chk("tx_valid_off1", tx_valid, 1'b0);
    chk("back_to_get_a", rx_ready, 1'b1);

    core_a_pow_d = res2;
    put_word(A2);
    rx_valid = 1'b0;
    chk("start_pulse2", core_start, 1'b1);
    chk("keep_n", core_n, N_VAL);
    chk("keep_d", core_d, D_VAL);
    recv(1'b1, res2, A2, 31, got);
    chk("tx_count2", got, 31);
    chk("tx_valid_off2", tx_valid, 1'b0);
    chk("start_count2", start_count, 2);

    key_reload = 1'b1;
    rx_data    = 8'hAA;
    rx_valid   = 1'b1;
    #1;
    chk("reload_rx_ready", rx_ready, 1'b0);
    @(posedge clk); #1;
    key_reload = 1'b0;
    rx_valid   = 1'b0;
    put_word(N2);
    rx_valid = 1'b0;
    chk("reload_n", core_n, N2);
    chk("reload_d_kept", core_d, D_VAL);
    chk("reload_a_kept", core_a, A2);

    core_a_pow_d = res1;
    put_word(D_VAL);
    put_word(A1);
    rx_valid = 1'b0;
    recv(1'b0, res1, A1, 5, got);
    chk("partial_count", got, 5);
    chk("still_sending", tx_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_tx_valid", tx_valid, 1'b0);
    chk("midrst_core_n", core_n, 256'h0);
    chk("midrst_core_d", core_d, 256'h0);
    rst = 1'b0;
    #1;
    chk("midrst_get_n", rx_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
